// File: rtl/redux_pkg.sv
// Shared definitions for the Redux-V controller: opcode constants,
// controller state encoding and ALU operation select.
package redux_pkg;

  localparam logic [3:0] OP_BRZR = 4'h0;
  localparam logic [3:0] OP_JI   = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_ADD  = 4'h9;
  localparam logic [3:0] OP_SUB  = 4'hA;
  localparam logic [3:0] OP_SLR  = 4'hB;
  localparam logic [3:0] OP_SRR  = 4'hC;
  localparam logic [3:0] OP_NOPD = 4'hD;
  localparam logic [3:0] OP_NOPE = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } ctrl_state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOT,
    ALU_SLR,
    ALU_SRR
  } alu_op_t;

endpackage

// File: rtl/redux_alu.sv
// Combinational 8-bit ALU for the Redux-V core. All arithmetic wraps mod 256.
// Build option: REDUX_SHIFT_EN adds the logical left/right shifter.
module redux_alu
  import redux_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  alu_op_t    op_i,
  output logic [7:0] y_o
);

  // Select the result for the requested operation; shifts use only b[2:0].
  always_comb begin
    y_o = 8'h00;
    case (op_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_XOR: y_o = a_i ^ b_i;
      ALU_NOT: y_o = ~b_i;
`ifdef REDUX_SHIFT_EN
      ALU_SLR: y_o = a_i << b_i[2:0];
      ALU_SRR: y_o = a_i >> b_i[2:0];
`endif
      default: y_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/redux_ctrl.sv
// Multi-cycle fetch/decode/execute controller for the Redux-V 8-bit core.
// Drives the register bank, instruction memory and data memory; both
// memories are synchronous-read with one cycle of latency.
// Build option: REDUX_SHIFT_EN enables SLR/SRR; otherwise they act as NOPs.
module redux_ctrl
  import redux_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] pc_out,
  input  logic [7:0] instr,
  output logic [1:0] r_a,
  output logic [1:0] r_b,
  input  logic [7:0] rf_a,
  input  logic [7:0] rf_b,
  output logic [1:0] write_addr,
  output logic [7:0] write_data,
  output logic       write_enable,
  output logic [7:0] dmem_addr,
  output logic [7:0] dmem_wdata,
  output logic       dmem_we,
  input  logic [7:0] dmem_rdata,
  output logic       halted
);

  ctrl_state_t state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  result_q, result_d;

  logic [3:0]  opc;
  logic        is_alu;
  alu_op_t     alu_op;
  logic [7:0]  alu_b;
  logic [7:0]  alu_y;
  logic [7:0]  pc_inc;

  assign opc    = ir_q[7:4];
  assign pc_inc = pc_q + 8'd1;

  // Map the opcode onto an ALU operation; ADDI feeds the zero-extended immediate.
  always_comb begin
    is_alu = 1'b0;
    alu_op = ALU_ADD;
    alu_b  = rf_b;
    case (opc)
      OP_ADDI: begin is_alu = 1'b1; alu_op = ALU_ADD; alu_b = {6'd0, ir_q[1:0]}; end
      OP_NOT:  begin is_alu = 1'b1; alu_op = ALU_NOT; end
      OP_AND:  begin is_alu = 1'b1; alu_op = ALU_AND; end
      OP_OR:   begin is_alu = 1'b1; alu_op = ALU_OR;  end
      OP_XOR:  begin is_alu = 1'b1; alu_op = ALU_XOR; end
      OP_ADD:  begin is_alu = 1'b1; alu_op = ALU_ADD; end
      OP_SUB:  begin is_alu = 1'b1; alu_op = ALU_SUB; end
`ifdef REDUX_SHIFT_EN
      OP_SLR:  begin is_alu = 1'b1; alu_op = ALU_SLR; end
      OP_SRR:  begin is_alu = 1'b1; alu_op = ALU_SRR; end
`endif
      default: is_alu = 1'b0;
    endcase
  end

  redux_alu u_alu (
    .a_i  (rf_a),
    .b_i  (alu_b),
    .op_i (alu_op),
    .y_o  (alu_y)
  );

  // Next-state, PC, IR and result-register sequencing.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    result_d = result_q;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        ir_d    = instr;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (opc)
          OP_BRZR: begin
            pc_d    = (rf_a == 8'h00) ? rf_b : pc_inc;
            state_d = ST_FETCH;
          end
          OP_JI: begin
            // Relative to the JI instruction's own address.
            pc_d    = pc_q + {{4{ir_q[3]}}, ir_q[3:0]};
            state_d = ST_FETCH;
          end
          OP_LD: begin
            pc_d    = pc_inc;
            state_d = ST_MEM;
          end
          OP_HALT: state_d = ST_HALT;
          default: begin
            pc_d = pc_inc;
            if (is_alu) begin
              result_d = alu_y;
              state_d  = ST_WB;
            end else begin
              state_d  = ST_FETCH;
            end
          end
        endcase
      end
      ST_MEM: begin
        result_d = dmem_rdata;
        state_d  = ST_WB;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Architectural state; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 8'h00;
      result_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      result_q <= result_d;
    end
  end

  // Strobes decode from state and IR only, so an async reset drops them at once.
  assign pc_out       = pc_q;
  assign r_a          = ir_q[3:2];
  assign r_b          = ir_q[1:0];
  assign write_addr   = ir_q[3:2];
  assign write_data   = result_q;
  assign write_enable = (state_q == ST_WB);
  assign dmem_addr    = rf_b;
  assign dmem_wdata   = rf_a;
  assign dmem_we      = (state_q == ST_EXEC) && (opc == OP_ST);
  assign halted       = (state_q == ST_HALT);

endmodule
